sprite_rom_arbiter: RTL

//  Shares one synchronous-read sprite ROM (512 x 8, 1-cycle read) between N_REQ sprite fetch engines.

---
 rtl/sprite_arb_pkg.sv | 30 +++
 rtl/sprite_rom_arbiter_pick.sv | 41 ++++
 rtl/sprite_rom_arbiter.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/sprite_arb_pkg.sv
// Sprite ROM arbiter shared types and helpers.
// Round-robin pick helper works on up to 8 requesters.
package sprite_arb_pkg;

  typedef enum logic {
    IDLE,
    BURST
  } state_t;

  localparam int N_REQ_DEF = 4;
  localparam int ID_W      = $clog2(N_REQ_DEF);
  localparam int PICK_W    = 8;

  // First set bit of v at or after ptr, wrapping at n.
  function automatic logic [PICK_W-1:0] rr_pick(
    input logic [PICK_W-1:0] v,
    input logic [2:0]        ptr,
    input int                n
  );
    logic [PICK_W-1:0] g;
    logic [2:0]        k;
    g = '0;
    for (int i = 0; i < PICK_W; i++) begin
      k = 3'((int'(ptr) + i) % n);
      if (i < n && g == '0 && v[k]) g[k] = 1'b1;
    end
    return g;
  endfunction

endpackage

// File: rtl/sprite_rom_arbiter_pick.sv
// rr_pick_arbiter: one-hot round-robin pick.
// mask0 gives requester 0 absolute priority.
module rr_pick_arbiter
  import sprite_arb_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int IW    = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] valid,
  input  logic [IW-1:0]    ptr,
  input  logic             mask0,
  output logic [N_REQ-1:0] grant,
  output logic [IW-1:0]    gid,
  output logic             any
);

  logic [PICK_W-1:0] v8;
  logic [PICK_W-1:0] g8;
  logic              unused_hi;

  // Rotating pick; requester 0 pre-empts the rotation when masked.
  always_comb begin
    v8 = '0;
    v8[N_REQ-1:0] = valid;
    if (mask0) v8[0] = 1'b0;
    g8 = rr_pick(v8, 3'(ptr), N_REQ);
    if (mask0 && valid[0]) g8 = 8'd1;
  end

  assign grant     = g8[N_REQ-1:0];
  assign unused_hi = ^g8;
  assign any       = |valid;

  // One-hot to index.
  always_comb begin
    gid = '0;
    for (int i = 0; i < N_REQ; i++)
      if (grant[i]) gid = IW'(i);
  end

endmodule

// File: rtl/sprite_rom_arbiter.sv
// Shares one sync sprite ROM among N_REQ burst fetchers.
// Define SPRITE_ARB_HIPRI_EN to give requester 0 priority.
module sprite_rom_arbiter
  import sprite_arb_pkg::*;
#(
  parameter int N_REQ   = N_REQ_DEF,
  parameter int ADDR_W  = 9,
  parameter int DATA_W  = 8,
  parameter int LEN_W   = 4,
  parameter int ROM_LAT = 1
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [N_REQ-1:0]          req_valid,
  input  logic [N_REQ*ADDR_W-1:0]   req_addr,
  input  logic [N_REQ*LEN_W-1:0]    req_len,
  output logic [N_REQ-1:0]          req_ready,
  output logic [ADDR_W-1:0]         rom_addr,
  output logic                      rom_en,
  input  logic [DATA_W-1:0]         rom_data,
  output logic                      rsp_valid,
  output logic [$clog2(N_REQ)-1:0]  rsp_id,
  output logic [DATA_W-1:0]         rsp_data,
  output logic                      rsp_last,
  output logic                      busy
);

  localparam int IW = $clog2(N_REQ);

  state_t             state;
  logic [ADDR_W-1:0]  cur;
  logic [LEN_W-1:0]   cnt;
  logic [IW-1:0]      id;
  logic [IW-1:0]      rr;
  logic [IW-1:0]      rr_nxt;
  logic [IW-1:0]      ptr;
  logic               last;
  logic               arb;
  logic               take;
  logic               any;
  logic               mask0;
  logic [N_REQ-1:0]   grant;
  logic [IW-1:0]      gid;
  logic [ROM_LAT-1:0] pv;
  logic [ROM_LAT-1:0] pl;
  logic [IW-1:0]      pid [ROM_LAT];

`ifdef SPRITE_ARB_HIPRI_EN
  assign mask0 = 1'b1;

  // Rotation skips requester 0; its bursts leave the pointer alone.
  always_comb begin
    rr_nxt = id + IW'(1);
    if (id == '0)
      rr_nxt = rr;
    else if (int'(id) == N_REQ - 1)
      rr_nxt = IW'(1);
  end
`else
  assign mask0 = 1'b0;

  // Pointer moves just past the finishing owner.
  always_comb begin
    rr_nxt = id + IW'(1);
    if (int'(id) == N_REQ - 1) rr_nxt = '0;
  end
`endif

  assign last = (state == BURST) && (cnt == '0);
  assign arb  = (state == IDLE) || last;
  assign ptr  = (state == BURST) ? rr_nxt : rr;
  assign take = arb && any;

  rr_pick_arbiter #(
    .N_REQ (N_REQ),
    .IW    (IW)
  ) u_pick (
    .valid (req_valid),
    .ptr   (ptr),
    .mask0 (mask0),
    .grant (grant),
    .gid   (gid),
    .any   (any)
  );

  assign req_ready = arb ? grant : '0;
  assign rom_en    = (state == BURST);
  assign rom_addr  = cur;

  // Burst FSM; a last beat can chain straight into the next grant.
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
      cur   <= '0;
      cnt   <= '0;
      id    <= '0;
      rr    <= '0;
    end else begin
      unique case (state)
        IDLE: ;
        BURST: begin
          cur <= cur + ADDR_W'(1);
          cnt <= cnt - LEN_W'(1);
          if (last) begin
            rr    <= rr_nxt;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
      if (take) begin
        cur   <= req_addr[int'(gid)*ADDR_W +: ADDR_W];
        cnt   <= req_len[int'(gid)*LEN_W +: LEN_W];
        id    <= gid;
        state <= BURST;
      end
    end
  end

  // Tag delay line matching the ROM read latency.
  always_ff @(posedge clock) begin
    if (reset) begin
      pv <= '0;
      pl <= '0;
      for (int i = 0; i < ROM_LAT; i++) pid[i] <= '0;
    end else begin
      pv[0]  <= rom_en;
      pl[0]  <= last;
      pid[0] <= id;
      for (int i = 1; i < ROM_LAT; i++) begin
        pv[i]  <= pv[i-1];
        pl[i]  <= pl[i-1];
        pid[i] <= pid[i-1];
      end
    end
  end

  assign rsp_valid = pv[ROM_LAT-1];
  assign rsp_last  = pl[ROM_LAT-1];
  assign rsp_id    = pid[ROM_LAT-1];
  assign rsp_data  = rom_data;
  assign busy      = rom_en | (|pv);

endmodule
